// File: rtl/uart_tx_top.sv
// uart_tx_top
// Transmit side of a UART. Bytes are pushed into a small circular FIFO with a
// write strobe; a framing FSM pops one byte at a time and serialises it as
// start bit, DATA_WIDTH data bits LSB-first, an optional parity bit and one
// stop bit. Every bit is held for BAUD_DIV clocks.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous reset, active low
//   wr_en      write strobe, accepted only while tx_full is low
//   d_in       byte to transmit
//   parity_en  append a parity bit to frames popped while high
//   parity_odd 1 = odd parity, 0 = even parity
//   tx         serial line, idle high, driven from a flop
//   tx_full    FIFO holds FIFO_DEPTH entries (registered)
//   tx_busy    framing FSM is not idle (registered)

module uart_tx_top #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int BAUD_DIV   = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] d_in,
    input  logic                  parity_en,
    input  logic                  parity_odd,
    output logic                  tx,
    output logic                  tx_full,
    output logic                  tx_busy
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BAUD_W = $clog2(BAUD_DIV);
    localparam int BIT_W  = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  state_q;
    logic [BAUD_W-1:0]       baud_q;
    logic [BIT_W-1:0]        bit_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic                    par_q;
    logic                    pen_q;
    logic                    tx_q;
    logic                    busy_q;

    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wptr_q;
    logic [PTR_W-1:0]        rptr_q;
    logic [CNT_W-1:0]        count_q;
    logic [CNT_W-1:0]        count_d;
    logic                    full_q;

    logic                    push;
    logic                    pop;
    logic                    baudLast;
    logic [DATA_WIDTH-1:0]   head;

    // A write is only looked at when the registered full flag is low, so a
    // push coinciding with a pop on a full FIFO is still dropped.
    assign push     = wr_en && !full_q;
    assign pop      = (state_q == S_IDLE) && (count_q != '0);
    assign baudLast = (baud_q == BAUD_W'(BAUD_DIV - 1));
    assign head     = mem_q[rptr_q];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset: an entry is only ever read after it was written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= d_in;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(FIFO_DEPTH));
        end
    end

    // Framing FSM. tx is registered from the current state, so the line lags
    // the state by one clock; every bit still lasts exactly BAUD_DIV clocks.
    // The parity bit is computed from the whole byte at pop time because the
    // shift register is consumed while the data bits go out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            pen_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q   <= 1'b1;
                    baud_q <= '0;
                    if (pop) begin
                        shift_q <= head;
                        par_q   <= (^head) ^ parity_odd;
                        pen_q   <= parity_en;
                        bit_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    tx_q <= 1'b0;
                    if (baudLast) begin
                        baud_q  <= '0;
                        state_q <= S_DATA;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    tx_q <= shift_q[0];
                    if (baudLast) begin
                        baud_q  <= '0;
                        shift_q <= shift_q >> 1;
                        if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
                            state_q <= pen_q ? S_PARITY : S_STOP;
                        end else begin
                            bit_q <= bit_q + BIT_W'(1);
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                S_PARITY: begin
                    tx_q <= par_q;
                    if (baudLast) begin
                        baud_q  <= '0;
                        state_q <= S_STOP;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                S_STOP: begin
                    tx_q <= 1'b1;
                    if (baudLast) begin
                        baud_q  <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    baud_q  <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign tx      = tx_q;
    assign tx_full = full_q;
    assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_top.sv
// tb_uart_tx_top
// Self-checking bench for uart_tx_top. A serial decoder in the bench samples
// tx in the middle of every bit and rebuilds each frame, which is then
// compared against hand-computed values from a vector table and a few
// hand-written sequences (FIFO full, reset mid-frame, random bytes).

module tb_uart_tx_top;

    localparam int B = 7;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] d_in;
    logic       parity_en;
    logic       parity_odd;
    logic       tx;
    logic       tx_full;
    logic       tx_busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] data;
        bit         pen;
        bit         podd;
        bit         toggle;
        bit         expPar;
        int         expLen;
    } vec_t;

    vec_t vecs [7];

    logic [7:0] rdData;
    logic       rdPar;
    logic       rdStop;
    int         sc;
    int         b0;
    int         b1;
    bit         found;
    logic [7:0] rnd;
    bit         rPen;
    bit         rOdd;

    logic [7:0] frData;
    logic       frPar;
    logic       frStop;
    int         frSc;
    int         frPrev;
    bit         frFound;

    uart_tx_top #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (8),
        .BAUD_DIV   (B)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .d_in       (d_in),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .tx         (tx),
        .tx_full    (tx_full),
        .tx_busy    (tx_busy)
    );

    // Free-running clock and a posedge cycle counter that is stable when
    // read on the falling edge.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one write for exactly one rising edge; returns on the falling
    // edge after the write edge.
    task automatic applyStimulus(input logic [7:0] d, input bit pen, input bit podd);
        @(negedge clk);
        wr_en      = 1'b1;
        d_in       = d;
        parity_en  = pen;
        parity_odd = podd;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic waitStart(input int bound, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (tx === 1'b0) seen = 1'b1;
        end
    endtask

    task automatic waitIdle(input int bound, output bit done);
        done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            @(negedge clk);
            if (tx_busy === 1'b0) done = 1'b1;
        end
    endtask

    // Decode one frame from tx, sampling each bit at its centre. Returns in
    // the middle of the stop bit.
    task automatic captureFrame(input bit pen, input bit toggle, output logic [7:0] data,
                                output logic par, output logic stopBit, output int startCyc,
                                output bit seen);
        data     = '0;
        par      = 1'b0;
        stopBit  = 1'b0;
        startCyc = 0;
        waitStart(300, seen);
        checkOutput("start bit seen", {31'b0, seen}, 32'd1);
        if (!seen) return;
        startCyc = cyc;
        if (toggle) parity_odd = ~parity_odd;
        repeat (B / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            repeat (B) @(negedge clk);
            data[k] = tx;
        end
        if (pen) begin
            repeat (B) @(negedge clk);
            par = tx;
        end
        repeat (B) @(negedge clk);
        stopBit = tx;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset      = 1'b0;
        wr_en      = 1'b0;
        d_in       = '0;
        parity_en  = 1'b0;
        parity_odd = 1'b0;

        // data, pen, podd, toggle-odd-mid-frame, expected parity, busy length
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 10 * B};
        vecs[1] = '{8'h55, 1'b1, 1'b1, 1'b0, 1'b1, 11 * B};
        vecs[2] = '{8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 11 * B};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 11 * B};
        vecs[4] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 11 * B};
        vecs[5] = '{8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 11 * B};
        vecs[6] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 10 * B};

        #12;
        checkOutput("reset tx", {31'b0, tx}, 32'd1);
        checkOutput("reset busy", {31'b0, tx_busy}, 32'd0);
        checkOutput("reset full", {31'b0, tx_full}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle tx", {31'b0, tx}, 32'd1);

        // Table-driven single frames.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].data, vecs[i].pen, vecs[i].podd);
            checkOutput("busy before pop", {31'b0, tx_busy}, 32'd0);
            @(negedge clk);
            checkOutput("busy after pop", {31'b0, tx_busy}, 32'd1);
            checkOutput("tx high at pop", {31'b0, tx}, 32'd1);
            b0 = cyc;
            captureFrame(vecs[i].pen, vecs[i].toggle, rdData, rdPar, rdStop, sc, found);
            checkOutput("start latency", sc - b0, 32'd1);
            checkOutput("frame data", {24'b0, rdData}, {24'b0, vecs[i].data});
            checkOutput("stop bit", {31'b0, rdStop}, 32'd1);
            if (vecs[i].pen) begin
                checkOutput("parity bit", {31'b0, rdPar}, {31'b0, vecs[i].expPar});
            end
            waitIdle(50, found);
            checkOutput("busy falls", {31'b0, found}, 32'd1);
            b1 = cyc;
            checkOutput("busy length", b1 - b0, vecs[i].expLen);
        end

        // FIFO full: nine writes while the first frame is going out, then a
        // dropped tenth write, drained in order with back-to-back spacing.
        doReset();
        fork
            begin
                for (int i = 1; i <= 9; i++) begin
                    @(negedge clk);
                    if (i == 9) checkOutput("not full at 7", {31'b0, tx_full}, 32'd0);
                    wr_en     = 1'b1;
                    d_in      = 8'(i);
                    parity_en = 1'b0;
                end
                @(negedge clk);
                checkOutput("full after 9", {31'b0, tx_full}, 32'd1);
                d_in = 8'h0A;
                @(negedge clk);
                wr_en = 1'b0;
                checkOutput("still full", {31'b0, tx_full}, 32'd1);
            end
            begin
                frPrev = 0;
                for (int f = 0; f < 9; f++) begin
                    captureFrame(1'b0, 1'b0, frData, frPar, frStop, frSc, frFound);
                    checkOutput("fifo order", {24'b0, frData}, 32'(f + 1));
                    checkOutput("fifo stop", {31'b0, frStop}, 32'd1);
                    if (f > 0) checkOutput("start spacing", frSc - frPrev, 32'(10 * B + 1));
                    frPrev = frSc;
                end
            end
        join
        waitStart(150, found);
        checkOutput("dropped write", {31'b0, found}, 32'd0);
        checkOutput("full cleared", {31'b0, tx_full}, 32'd0);

        // Reset during data bit 3 with a full FIFO behind it.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            wr_en = 1'b1;
            d_in  = 8'(8'h40 + i);
        end
        @(negedge clk);
        wr_en = 1'b0;
        checkOutput("full before reset", {31'b0, tx_full}, 32'd1);
        repeat (24) @(negedge clk);
        checkOutput("busy before reset", {31'b0, tx_busy}, 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("abort tx", {31'b0, tx}, 32'd1);
        checkOutput("abort busy", {31'b0, tx_busy}, 32'd0);
        checkOutput("abort full", {31'b0, tx_full}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        waitStart(150, found);
        checkOutput("queue lost", {31'b0, found}, 32'd0);
        applyStimulus(8'h3C, 1'b0, 1'b0);
        captureFrame(1'b0, 1'b0, rdData, rdPar, rdStop, sc, found);
        checkOutput("after reset data", {24'b0, rdData}, 32'h3C);
        waitIdle(50, found);

        // Random bytes and parity modes through the bench decoder.
        for (int i = 0; i < 20; i++) begin
            rnd  = 8'($urandom_range(0, 255));
            rPen = 1'($urandom_range(0, 1));
            rOdd = 1'($urandom_range(0, 1));
            applyStimulus(rnd, rPen, rOdd);
            captureFrame(rPen, 1'b0, rdData, rdPar, rdStop, sc, found);
            checkOutput("random data", {24'b0, rdData}, {24'b0, rnd});
            checkOutput("random stop", {31'b0, rdStop}, 32'd1);
            if (rPen) checkOutput("random parity", {31'b0, rdPar}, {31'b0, (^rnd) ^ rOdd});
            waitIdle(50, found);
            checkOutput("random idle", {31'b0, found}, 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
